// File: rtl/pst.sv
// pst: write-side skid front-end for the registered-output FIFO; two-entry
// in-order buffer between producer and FIFO. Optional macro: PST_WR_OVF_CNT_EN.
module pst #(
   parameter int W  = 8,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   output logic          wr_vld,
   output logic          fifo_wr_en,
   output logic [W-1:0]  fifo_wr_data,
   input  logic          fifo_full,
   output logic          pst_wr_empty,
   output logic          pst_wr_full,
   input  logic          ovf_clr,
   output logic          ovf_flag,
   output logic [CW-1:0] ovf_cnt
);

   logic [1:0]   cnt;
   logic [1:0]   cnt_next;
   logic [1:0]   cnt_left;
   logic [W-1:0] head;
   logic [W-1:0] head_next;
   logic [W-1:0] tail;
   logic [W-1:0] tail_next;
   logic         wr_vld_next;
   logic         acc;
   logic         drain;

   assign acc          = wr_en & wr_vld;
   assign drain        = (cnt != 2'd0) & ~fifo_full;
   assign fifo_wr_en   = drain;
   assign fifo_wr_data = head;
   assign pst_wr_empty = (cnt == 2'd0);
   assign pst_wr_full  = (cnt == 2'd2);

   // Occupancy left after this cycle's drain decides which slot takes the new word.
   assign cnt_left = cnt - {1'b0, drain};

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      head_next = head;
      tail_next = tail;
      if (drain) begin
         head_next = tail;
      end
      if (acc) begin
         if (cnt_left == 2'd0) begin
            head_next = wr_data;
         end else begin
            tail_next = wr_data;
         end
      end
      cnt_next    = cnt + {1'b0, acc} - {1'b0, drain};
      wr_vld_next = (cnt_next < 2'd2);
   end

   // NOTE: the data registers are reset too, because fifo_wr_data is visible as 0 in reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= 2'd0;
         head   <= '0;
         tail   <= '0;
         wr_vld <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep all state updates on the same edge.
         cnt    <= cnt_next;
         head   <= head_next;
         tail   <= tail_next;
         wr_vld <= wr_vld_next;
      end
   end

`ifdef PST_WR_OVF_CNT_EN
   logic ovf_ev;

   assign ovf_ev = wr_en & ~wr_vld;

   // A clear in the same cycle as an event restarts the count at that event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_flag <= 1'b0;
         ovf_cnt  <= '0;
      end else if (ovf_clr) begin
         ovf_flag <= ovf_ev;
         ovf_cnt  <= ovf_ev ? CW'(1) : '0;
      end else if (ovf_ev) begin
         ovf_flag <= 1'b1;
         if (ovf_cnt != '1) begin
            ovf_cnt <= ovf_cnt + CW'(1);
         end
      end
   end
`else
   logic unused_ovf_clr;

   assign unused_ovf_clr = ovf_clr;
   assign ovf_flag       = 1'b0;
   assign ovf_cnt        = '0;
`endif

endmodule

// File: tb/tb_pst.sv
// tb_pst: directed bench for pst with a queue-based reference model and a
// per-cycle compare on the falling edge.
module tb_pst;

   localparam int W     = 8;
   localparam int TB_CW = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             wr_en;
   logic [W-1:0]     wr_data;
   logic             wr_vld;
   logic             fifo_wr_en;
   logic [W-1:0]     fifo_wr_data;
   logic             fifo_full;
   logic             pst_wr_empty;
   logic             pst_wr_full;
   logic             ovf_clr;
   logic             ovf_flag;
   logic [TB_CW-1:0] ovf_cnt;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   pst #(.W(W), .CW(TB_CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .wr_vld       (wr_vld),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .fifo_full    (fifo_full),
      .pst_wr_empty (pst_wr_empty),
      .pst_wr_full  (pst_wr_full),
      .ovf_clr      (ovf_clr),
      .ovf_flag     (ovf_flag),
      .ovf_cnt      (ovf_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: the buffer is a queue of accepted words, ready is the
   // registered "fewer than two held" condition.
   logic [W-1:0] mq[$];
   bit           m_vld  = 1'b0;
   bit           m_flag = 1'b0;
   int           m_ocnt = 0;

   always @(posedge clk or posedge rst) begin
      bit acc;
      bit drain;
      bit ev;
      if (rst) begin
         mq.delete();
         m_vld  = 1'b0;
         m_flag = 1'b0;
         m_ocnt = 0;
      end else begin
         acc   = wr_en && m_vld;
         drain = (mq.size() != 0) && !fifo_full;
         ev    = wr_en && !m_vld;
         if (drain) void'(mq.pop_front());
         if (acc) mq.push_back(wr_data);
         m_vld = (mq.size() < 2);
`ifdef PST_WR_OVF_CNT_EN
         if (ovf_clr) begin
            m_flag = ev;
            m_ocnt = ev ? 1 : 0;
         end else if (ev) begin
            m_flag = 1'b1;
            if (m_ocnt < (1 << TB_CW) - 1) m_ocnt++;
         end
`else
         if (ev) begin
            m_flag = 1'b0;
            m_ocnt = 0;
         end
`endif
      end
   end

   // Log of every word the DUT hands to the FIFO, with the cycle it appeared.
   logic [W-1:0] wlog[$];
   int           wcyc[$];

   always @(negedge clk) begin
      bit exp_en;
      exp_en = (mq.size() != 0) && !fifo_full;
      check("wr_vld", wr_vld, m_vld);
      check("fifo_wr_en", fifo_wr_en, exp_en);
      check("pst_wr_empty", pst_wr_empty, mq.size() == 0);
      check("pst_wr_full", pst_wr_full, mq.size() == 2);
      if (exp_en) check("fifo_wr_data", fifo_wr_data, mq[0]);
      if (rst) check("rst_fifo_wr_data", fifo_wr_data, 0);
      check("ovf_flag", ovf_flag, m_flag);
      check("ovf_cnt", ovf_cnt, m_ocnt);
      if (fifo_wr_en === 1'b1) begin
         wlog.push_back(fifo_wr_data);
         wcyc.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [W-1:0] d);
      bit v;
      int n;
      n       = 0;
      wr_en   = 1'b1;
      wr_data = d;
      forever begin
         v = wr_vld;
         tick();
         if (v) break;
         n++;
         if (n > 50) begin
            check("push_timeout", 1, 0);
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] d;
      bit           v;
      int           acc_n;
      int           drive_cyc;

      rst = 1'b0; wr_en = 1'b0; wr_data = '0; fifo_full = 1'b0; ovf_clr = 1'b0;
      #1 rst = 1'b1;

      // Reset and idle
      repeat (3) tick();
      check("rst_wr_vld", wr_vld, 0);
      check("rst_empty", pst_wr_empty, 1);
      check("rst_fifo_wr_en", fifo_wr_en, 0);
      rst = 1'b0;
      #1 check("vld_before_edge", wr_vld, 0);
      tick();
      check("vld_after_edge", wr_vld, 1);

      // Streaming 0x01..0x10
      wlog.delete(); wcyc.delete();
      drive_cyc = cyc;
      for (int i = 1; i <= 16; i++) begin
         wr_en   = 1'b1;
         wr_data = W'(i);
         #1 check("stream_vld", wr_vld, 1);
         tick();
      end
      wr_en = 1'b0;
      repeat (3) tick();
      check("stream_count", wlog.size(), 16);
      for (int k = 0; k < wlog.size() && k < 16; k++) begin
         check("stream_data", wlog[k], k + 1);
         check("stream_cycle", wcyc[k], drive_cyc + 1 + k);
      end

      // Backpressure: FIFO held full
      wlog.delete();
      fifo_full = 1'b1;
      d         = 8'hA0;
      acc_n     = 0;
      for (int i = 0; i < 5; i++) begin
         wr_en   = 1'b1;
         wr_data = d;
         v       = wr_vld;
         tick();
         if (v) begin
            d++;
            acc_n++;
         end
      end
      check("bp_accepted", acc_n, 2);
      check("bp_vld_low", wr_vld, 0);
      check("bp_skid_full", pst_wr_full, 1);
      check("bp_no_write", wlog.size(), 0);
`ifdef PST_WR_OVF_CNT_EN
      check("ovf_flag_set", ovf_flag, 1);
      check("ovf_cnt_3", ovf_cnt, 3);
`else
      check("ovf_flag_tied", ovf_flag, 0);
      check("ovf_cnt_tied", ovf_cnt, 0);
`endif

      // Clear coinciding with one more event, then saturate
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
`ifdef PST_WR_OVF_CNT_EN
      check("ovf_clr_event_flag", ovf_flag, 1);
      check("ovf_clr_event_cnt", ovf_cnt, 1);
`endif
      repeat (16) tick();
`ifdef PST_WR_OVF_CNT_EN
      check("ovf_saturate", ovf_cnt, 4'hF);
`endif

      // fifo_full low for one cycle at cnt = 2
      fifo_full = 1'b0;
      #1 check("pulse_drain", fifo_wr_en, 1);
      check("pulse_data", fifo_wr_data, 8'hA0);
      tick();
      fifo_full = 1'b1;
      check("pulse_cnt1", pst_wr_full, 0);
      check("pulse_vld_rise", wr_vld, 1);
      wr_data = d;
      v       = wr_vld;
      tick();
      if (v) d++;
      check("refill_full", pst_wr_full, 1);
      check("refill_vld_low", wr_vld, 0);

      // Release
      wr_data   = d;
      fifo_full = 1'b0;
      #1 check("rel_vld_still_low", wr_vld, 0);
      check("rel_drain", fifo_wr_en, 1);
      tick();
      check("rel_vld_high", wr_vld, 1);
      while (d <= 8'hA5) begin
         push_word(d);
         d++;
      end
      wr_en = 1'b0;
      repeat (4) tick();
      check("bp_total", wlog.size(), 6);
      for (int k = 0; k < wlog.size() && k < 6; k++) begin
         check("bp_order", wlog[k], 8'hA0 + k);
      end

      // Reset mid-burst with two buffered words
      wlog.delete();
      fifo_full = 1'b1;
      push_word(8'hC0);
      push_word(8'hC1);
      wr_en = 1'b0;
      check("mid_full", pst_wr_full, 1);
      rst = 1'b1;
      #1 check("mid_rst_wr_en", fifo_wr_en, 0);
      check("mid_rst_empty", pst_wr_empty, 1);
      check("mid_rst_vld", wr_vld, 0);
      check("mid_rst_data", fifo_wr_data, 0);
      fifo_full = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
      check("mid_vld_back", wr_vld, 1);
      repeat (4) tick();
      check("mid_discarded", wlog.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
